// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: one full-adder cell plus carry flop, start/busy/done handshake.
// Optional two's-complement overflow output Ovf is built when SERIAL_ADD_OVF_EN is defined.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             CarryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_s;
    logic             carry_nxt_s;
    logic [WIDTH-1:0] sum_shift_s;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-adder cell and the collected-sum shift with the new bit entering at the MSB.
    always_comb begin
        bit_s       = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        carry_nxt_s = majority(a_sr_q[0], b_sr_q[0], carry_q);
        sum_shift_s = {bit_s, {(WIDTH-1){1'b0}}} | (sum_sr_q >> 1);
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A start in DONE is accepted back-to-back; sum/Cout stay held until the next done.
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = CarryIn;
                    sum_sr_d = {WIDTH{1'b0}};
                    cnt_d    = {CW{1'b0}};
                    busy_d   = 1'b1;
                    state_d  = ST_ADD;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ADD: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = carry_nxt_s;
                sum_sr_d = sum_shift_s;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_shift_s;
                    cout_d  = carry_nxt_s;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ carry_nxt_s;
`endif
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    busy_d  = 1'b1;
                    state_d = ST_ADD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= {WIDTH{1'b0}};
            b_sr_q   <= {WIDTH{1'b0}};
            sum_sr_q <= {WIDTH{1'b0}};
            sum_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8), with Ovf checks when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .CarryIn (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .Cout    (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .Ovf     (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_held(input string tag);
        chk({tag, " sum_held"}, 32'(sum), 32'(held_sum));
        chk({tag, " cout_held"}, 32'(cout), 32'(held_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, " ovf_held"}, 32'(ovf), 32'(held_ovf));
`endif
    endtask

    task automatic launch(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic hold);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, " done_after_start"}, 32'(done), 32'd0);
    endtask

    // Waits for done (bounded), disturbing inputs mid-operation, then checks result and timing.
    task automatic finish(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
        int n  = 1;
        int bc = 1;
        while (done !== 1'b1 && n < 20) begin
            chk_held(tag);
            if (n == 4) begin
                a   = ~a;
                b   = ~b;
                cin = ~cin;
            end
            if (n == 7) start = 1'b0;
            step();
            n++;
            if (busy === 1'b1) bc++;
            chk({tag, " busy_and_done"}, 32'(busy & done), 32'd0);
        end
        chk({tag, " latency_edges"}, 32'(n), 32'd9);
        chk({tag, " busy_cycles"}, 32'(bc), 32'd8);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " sum"}, 32'(sum), 32'(es));
        chk({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, " ovf"}, 32'(ovf), 32'(eo));
`endif
        held_sum  = es;
        held_cout = ec;
        held_ovf  = eo;
    endtask

    task automatic after_done(input string tag);
        step();
        chk({tag, " done_single_pulse"}, 32'(done), 32'd0);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        chk_held(tag);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        held_sum  = 8'h00;
        held_cout = 1'b0;
        held_ovf  = 1'b0;

        // Reset with start high: reset wins.
        step();
        step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk_held("reset");
        reset = 1'b0;
        start = 1'b0;
        step();
        chk("idle busy", 32'(busy), 32'd0);

        // Basic sums.
        launch("t1", 8'h5A, 8'h3C, 1'b0, 1'b0);
        finish("t1", 8'h96, 1'b0, 1'b1);
        after_done("t1");

        launch("t2a", 8'hFF, 8'h01, 1'b0, 1'b0);
        finish("t2a", 8'h00, 1'b1, 1'b0);
        after_done("t2a");

        launch("t2b", 8'h00, 8'h00, 1'b1, 1'b0);
        finish("t2b", 8'h01, 1'b0, 1'b0);
        after_done("t2b");

        // start held through ADD; operands flipped mid-operation.
        launch("t3", 8'h12, 8'h34, 1'b1, 1'b1);
        finish("t3", 8'h47, 1'b0, 1'b0);
        after_done("t3");

        // Back-to-back start in the DONE cycle.
        launch("t4a", 8'hC8, 8'h64, 1'b0, 1'b0);
        finish("t4a", 8'h2C, 1'b1, 1'b0);
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4 b2b busy", 32'(busy), 32'd1);
        chk("t4 b2b done", 32'(done), 32'd0);
        chk_held("t4 b2b");
        finish("t4b", 8'h03, 1'b0, 1'b0);
        after_done("t4b");

        launch("t4c", 8'h80, 8'h80, 1'b1, 1'b0);
        finish("t4c", 8'h01, 1'b1, 1'b1);
        after_done("t4c");

        // Reset sampled on the edge that would process bit 4.
        launch("t5", 8'h0F, 8'hF0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5 busy_after_reset", 32'(busy), 32'd0);
        chk("t5 done_after_reset", 32'(done), 32'd0);
        chk("t5 sum_after_reset", 32'(sum), 32'd0);
        chk("t5 cout_after_reset", 32'(cout), 32'd0);
        held_sum  = 8'h00;
        held_cout = 1'b0;
        held_ovf  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t5 no_done_after_abort", 32'(done), 32'd0);
        end
        launch("t5b", 8'h0F, 8'hF0, 1'b0, 1'b0);
        finish("t5b", 8'hFF, 1'b0, 1'b0);
        after_done("t5b");

`ifdef SERIAL_ADD_OVF_EN
        launch("t6a", 8'h7F, 8'h01, 1'b0, 1'b0);
        finish("t6a", 8'h80, 1'b0, 1'b1);
        after_done("t6a");
        launch("t6b", 8'hFF, 8'h01, 1'b0, 1'b0);
        finish("t6b", 8'h00, 1'b1, 1'b0);
        after_done("t6b");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
